// File: rtl/uart_mmio_pkg.sv
// Shared constants and FSM state types for the memory-mapped UART responder.
package uart_mmio_pkg;

  localparam logic [31:0] TXD_OFS = 32'h0;
  localparam logic [31:0] RXD_OFS = 32'h4;
  localparam logic [31:0] CON_OFS = 32'h8;

  localparam int unsigned CON_TX_IDLE  = 0;
  localparam int unsigned CON_TX_FULL  = 1;
  localparam int unsigned CON_RX_VALID = 2;
  localparam int unsigned CON_OVR      = 3;
  localparam int unsigned CON_RX_IE    = 4;
  localparam int unsigned CON_LB       = 5;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; a push on a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// MEM-stage bus responder for an 8N1 UART: TXD/RXD/CON registers, TX FIFO,
// TX/RX FSMs. Define UART_LOOPBACK_EN to implement CON.lb (RX fed from TX).
module uart_mmio_responder
  import uart_mmio_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned BAUD          = 9600,
  parameter int unsigned TX_FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned DIV       = CLK_FREQ / BAUD;
  localparam int unsigned HALF      = DIV / 2;
  localparam int unsigned CW        = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [31:0] ADDR_TXD  = BASE_ADDR + TXD_OFS;
  localparam logic [31:0] ADDR_RXD  = BASE_ADDR + RXD_OFS;
  localparam logic [31:0] ADDR_CON  = BASE_ADDR + CON_OFS;

  logic sel_txd, sel_rxd, sel_con;
  logic tx_push, rd_rxd, con_wr;

  logic       fifo_empty, fifo_full;
  logic [7:0] fifo_dout;

  tx_state_t  tx_state, tx_next;
  logic [CW-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0] tx_bit, tx_bit_nxt;
  logic [7:0] tx_shift, tx_shift_nxt;
  logic       tx_pop, tx_line, tx_line_nxt, tx_tick, tx_idle;

  rx_state_t  rx_state, rx_next;
  logic [CW-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0] rx_bit, rx_bit_nxt;
  logic [7:0] rx_shift, rx_shift_nxt;
  logic [1:0] rx_sync;
  logic       rx_prev, rx_s, rx_fall, rx_src, rx_done;
  logic       rx_tick, rx_half_tick;

  logic [7:0] rx_data;
  logic       rx_valid, ovr, rx_ie, lb;
  logic [5:0] con_val;
  logic       unused_wd;

  assign sel_txd = (Address == ADDR_TXD);
  assign sel_rxd = (Address == ADDR_RXD);
  assign sel_con = (Address == ADDR_CON);
  assign tx_push = MemWrite & sel_txd;
  assign rd_rxd  = MemRead & sel_rxd;
  assign con_wr  = MemWrite & sel_con;
  assign unused_wd = ^Write_data[31:8];

  uart_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (Write_data[7:0]),
    .pop   (tx_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // ---------------- TX ----------------
  assign tx_tick = (tx_cnt == BIT_LAST);
  assign tx_idle = fifo_empty & (tx_state == TX_IDLE);
  assign uart_tx = tx_line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (!fifo_empty) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = fifo_empty ? TX_IDLE : TX_START;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // Line level is registered from the next state so it changes with the state.
  always_comb begin
    tx_pop       = 1'b0;
    tx_shift_nxt = tx_shift;
    tx_bit_nxt   = tx_bit;
    tx_cnt_nxt   = tx_tick ? '0 : tx_cnt + CW'(1);
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nxt = '0;
        if (!fifo_empty) begin
          tx_pop       = 1'b1;
          tx_shift_nxt = fifo_dout;
        end
      end
      TX_START: if (tx_tick) tx_bit_nxt = 3'd0;
      TX_DATA: if (tx_tick) begin
        tx_shift_nxt = {1'b0, tx_shift[7:1]};
        tx_bit_nxt   = tx_bit + 3'd1;
      end
      TX_STOP: if (tx_tick && !fifo_empty) begin
        tx_pop       = 1'b1;
        tx_shift_nxt = fifo_dout;
      end
      default: ;
    endcase
    case (tx_next)
      TX_START: tx_line_nxt = 1'b0;
      TX_DATA:  tx_line_nxt = tx_shift_nxt[0];
      default:  tx_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      tx_line  <= tx_line_nxt;
    end
  end

  // ---------------- RX ----------------
  assign rx_src       = lb ? tx_line : uart_rx;
  assign rx_s         = rx_sync[1];
  assign rx_fall      = rx_prev & ~rx_s;
  assign rx_tick      = (rx_cnt == BIT_LAST);
  assign rx_half_tick = (rx_cnt == HALF_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx_src};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_half_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_nxt   = rx_cnt + CW'(1);
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_done      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nxt = '0;
        rx_bit_nxt = 3'd0;
      end
      RX_START: if (rx_half_tick) rx_cnt_nxt = '0;
      RX_DATA: if (rx_tick) begin
        rx_cnt_nxt   = '0;
        rx_shift_nxt = {rx_s, rx_shift[7:1]};
        rx_bit_nxt   = rx_bit + 3'd1;
      end
      RX_STOP: if (rx_tick) begin
        rx_cnt_nxt = '0;
        rx_done    = rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  // ---------------- CON / RX data ----------------
  // An overrun set in the same cycle as a clear wins, so no lost byte goes unreported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ovr      <= 1'b0;
      rx_ie    <= 1'b0;
    end else begin
      if (con_wr && Write_data[CON_OVR]) ovr <= 1'b0;
      if (rx_done && rx_valid && !rd_rxd) ovr <= 1'b1;
      if (rx_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_rxd) begin
        rx_valid <= 1'b0;
      end
      if (con_wr) rx_ie <= Write_data[CON_RX_IE];
    end
  end

`ifdef UART_LOOPBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       lb <= 1'b0;
    else if (con_wr) lb <= Write_data[CON_LB];
  end
`else
  assign lb = 1'b0;
`endif

  assign irq     = rx_valid & rx_ie;
  assign con_val = {lb, rx_ie, ovr, rx_valid, fifo_full, tx_idle};

  always_comb begin
    Read_data = '0;
    if (sel_rxd)      Read_data = {24'b0, rx_data};
    else if (sel_con) Read_data = 32'(con_val);
  end

endmodule
